// File: rtl/uart_tx_packetizer.sv
`default_nettype none
// ============================================================================
// uart_tx_packetizer: buffers N_WORDS result words, sends HEADER/len/data/XOR
// Rev 1.0 - initial release
// ============================================================================
module uart_tx_packetizer #(
   parameter int         N_WORDS = 4,
   parameter logic [7:0] HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_active,
   input  logic        tx_done,
   output logic        busy,
   output logic        pkt_done
);

   localparam int CNT_W     = $clog2(N_WORDS + 1);
   localparam int NUM_BYTES = 2 * N_WORDS + 3;
   localparam int IDX_W     = ($clog2(NUM_BYTES + 1) > 8) ? $clog2(NUM_BYTES + 1) : 8;
   localparam int WSEL_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);
   localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(NUM_BYTES);
   localparam logic [IDX_W-1:0] CHK_IDX   = IDX_W'(NUM_BYTES - 1);
   localparam logic [7:0]       LEN_BYTE  = 8'(N_WORDS);

   typedef enum logic [2:0] {
      COLLECT   = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      WAIT_IDLE = 3'd3,
      FINISH    = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    count;
   logic [IDX_W-1:0]    idx;
   logic [7:0]          chk;
   logic                seen_low;
   logic [15:0]         words [N_WORDS];
   logic [WSEL_W-1:0]   wsel;
   logic [7:0]          cur_byte;
   logic                accept;

   assign in_ready = (state == COLLECT) && (count <= LAST_WORD);
   assign busy     = (state != COLLECT);
   assign accept   = in_valid && in_ready;

   // idx counts bytes already issued, so it also selects the next byte to send
   always_comb begin
      wsel     = WSEL_W'((idx - IDX_W'(2)) >> 1);
      cur_byte = chk;
      if (idx == '0)
         cur_byte = HEADER;
      else if (idx == IDX_W'(1))
         cur_byte = LEN_BYTE;
      else if (idx < CHK_IDX)
         cur_byte = idx[0] ? words[wsel][7:0] : words[wsel][15:8];
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         COLLECT: begin
            if (accept && (count == LAST_WORD))
               state_nxt = ISSUE;
         end
         ISSUE:
            state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            // a tx_done still high from the previous byte must not count again
            if (seen_low && tx_done)
               state_nxt = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (!tx_done && !tx_active)
               state_nxt = (idx < TOTAL_IDX) ? ISSUE : FINISH;
         end
         FINISH:
            state_nxt = COLLECT;
         default:
            state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= COLLECT;
         count    <= '0;
         idx      <= '0;
         chk      <= '0;
         seen_low <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         pkt_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         tx_start <= (state_nxt == ISSUE);
         pkt_done <= (state_nxt == FINISH);
         if (state_nxt == ISSUE)
            tx_data <= cur_byte;
         if (accept)
            count <= count + 1'b1;
         case (state)
            ISSUE: begin
               idx      <= idx + 1'b1;
               seen_low <= 1'b0;
               if ((idx != '0) && (idx < CHK_IDX))
                  chk <= chk ^ tx_data;
            end
            WAIT_DONE: begin
               if (!tx_done)
                  seen_low <= 1'b1;
            end
            FINISH: begin
               count <= '0;
               idx   <= '0;
               chk   <= '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         words[count[WSEL_W-1:0]] <= in_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packetizer.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_packetizer: directed checks of packet framing and UART handshake
// Rev 1.0 - initial release
// ============================================================================
module tb_uart_tx_packetizer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_active;
   logic        tx_done;
   logic        busy;
   logic        pkt_done;

   logic        in_valid4;
   logic [15:0] in_data4;
   logic        in_ready4;
   logic        tx_start4;
   logic [7:0]  tx_data4;
   logic        tx_active4;
   logic        tx_done4;
   logic        busy4;
   logic        pkt_done4;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int pkts = 0;
   int pkts4 = 0;
   int violations = 0;
   int ready_busy = 0;
   int act_len = 2;
   int done_len = 1;
   logic [7:0] got[$];
   logic [7:0] got4[$];

   always #5 clk = ~clk;

   uart_tx_packetizer #(.N_WORDS(2), .HEADER(8'hA5)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_active(tx_active), .tx_done(tx_done), .busy(busy), .pkt_done(pkt_done)
   );

   uart_tx_packetizer dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_data(in_data4),
      .in_ready(in_ready4), .tx_start(tx_start4), .tx_data(tx_data4),
      .tx_active(tx_active4), .tx_done(tx_done4), .busy(busy4), .pkt_done(pkt_done4)
   );

   always @(negedge clk) begin
      if (tx_start) begin
         got.push_back(tx_data);
         starts++;
         if (tx_active || tx_done) violations++;
      end
      if (pkt_done) pkts++;
      if (busy && in_ready) ready_busy++;
      if (tx_start4) got4.push_back(tx_data4);
      if (pkt_done4) pkts4++;
   end

   // UART model: busy a few cycles, then tx_done for done_len cycles
   initial begin
      tx_active = 1'b0;
      tx_done   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start) begin
            @(posedge clk); #1 tx_active = 1'b1;
            repeat (act_len) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_active = 1'b0;
            repeat (done_len - 1) @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   initial begin
      tx_active4 = 1'b0;
      tx_done4   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start4) begin
            @(posedge clk); #1 tx_active4 = 1'b1;
            @(posedge clk); #1 tx_active4 = 1'b0; tx_done4 = 1'b1;
            @(posedge clk); #1 tx_done4 = 1'b0;
         end
      end
   end

   task automatic send_word(input logic [15:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_pkt(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (pkt_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got=%b want=0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got=%b want=0", pkt_done); end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [7:0] exp [7] = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      bit ok;
      int p0 = pkts;
      act_len = 2; done_len = 1;
      got.delete();
      send_word(16'h1234);
      send_word(16'hABCD);
      wait_pkt(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_pkt_timeout got=0 want=1"); end
      repeat (5) @(posedge clk); #1;
      checks++; if (got.size() !== 7) begin errors++; $display("FAIL basic_len got=%0d want=7", got.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got=%h want=%h", i, got[i], exp[i]); end
      end
      checks++; if (pkts - p0 !== 1) begin errors++; $display("FAIL basic_pkt_pulses got=%0d want=1", pkts - p0); end
      checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL basic_tx_data_hold got=%h want=42", tx_data); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got=%b%b want=01", busy, in_ready); end
   endtask

   task automatic test_long_done();
      // 02^0F^0F^80^01 = 83
      logic [7:0] exp [7] = '{8'hA5, 8'h02, 8'h0F, 8'h0F, 8'h80, 8'h01, 8'h83};
      bit ok;
      int s0 = starts;
      act_len = 3; done_len = 2;
      got.delete();
      send_word(16'h0F0F);
      send_word(16'h8001);
      wait_pkt(ok);
      checks++; if (!ok) begin errors++; $display("FAIL long_pkt_timeout got=0 want=1"); end
      repeat (5) @(posedge clk); #1;
      checks++; if (starts - s0 !== 7) begin errors++; $display("FAIL long_starts got=%0d want=7", starts - s0); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL long_byte%0d got=%h want=%h", i, got[i], exp[i]); end
      end
      checks++; if (violations !== 0) begin errors++; $display("FAIL long_start_while_busy got=%0d want=0", violations); end
   endtask

   task automatic test_hold_valid();
      logic [7:0] exp1 [7] = '{8'hA5, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h02};
      logic [7:0] exp2 [7] = '{8'hA5, 8'h02, 8'h5A, 8'h5A, 8'h01, 8'h02, 8'h01};
      bit ok;
      act_len = 2; done_len = 2;
      got.delete();
      send_word(16'h1111);
      send_word(16'h2222);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      wait_pkt(ok);
      in_valid = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL hold_pkt_timeout got=0 want=1"); end
      checks++; if (ready_busy !== 0) begin errors++; $display("FAIL hold_ready_while_busy got=%0d want=0", ready_busy); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp1[i]) begin errors++; $display("FAIL hold_pkt1_byte%0d got=%h want=%h", i, got[i], exp1[i]); end
      end
      repeat (3) @(posedge clk); #1;
      got.delete();
      send_word(16'h5A5A);
      send_word(16'h0102);
      wait_pkt(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_pkt2_timeout got=0 want=1"); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp2[i]) begin errors++; $display("FAIL hold_pkt2_byte%0d got=%h want=%h", i, got[i], exp2[i]); end
      end
   endtask

   task automatic test_reset_mid();
      // 02^00^01^00^02 = 01
      logic [7:0] exp [7] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
      bit ok;
      int n = 0;
      int p0;
      act_len = 2; done_len = 1;
      got.delete();
      send_word(16'h1234);
      send_word(16'hABCD);
      while (got.size() < 3 && n < 500) begin @(posedge clk); #1; n++; end
      checks++; if (got.size() < 3) begin errors++; $display("FAIL mid_third_byte_timeout got=%0d want=3", got.size()); end
      reset_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_busy got=%b%b want=10", in_ready, busy); end
      checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_tx got=%b/%h want=0/00", tx_start, tx_data); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL mid_rst_pkt_done got=%b want=0", pkt_done); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      got.delete();
      p0 = pkts;
      send_word(16'h0001);
      send_word(16'h0002);
      wait_pkt(ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_pkt_timeout got=0 want=1"); end
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d got=%h want=%h", i, got[i], exp[i]); end
      end
      checks++; if (pkts - p0 !== 1) begin errors++; $display("FAIL mid_pkt_pulses got=%0d want=1", pkts - p0); end
   endtask

   task automatic test_bursts();
      // 02^C0^01^3C^02 = FD
      logic [7:0] exp [7] = '{8'hA5, 8'h02, 8'hC0, 8'h01, 8'h3C, 8'h02, 8'hFD};
      bit ok;
      act_len = 1; done_len = 3;
      got.delete();
      repeat (2) @(posedge clk); #1;
      send_word(16'hC001);
      repeat (3) @(posedge clk); #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL burst_early_start got=%b want=0", tx_start); end
      in_valid = 1'b1;
      in_data  = 16'h3C02;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL burst_first_start got=%b/%h want=1/a5", tx_start, tx_data); end
      wait_pkt(ok);
      checks++; if (!ok) begin errors++; $display("FAIL burst_pkt_timeout got=0 want=1"); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL burst_byte%0d got=%h want=%h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_default_words();
      logic [7:0] exp [11] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
      int n = 0;
      int p0 = pkts4;
      got4.delete();
      in_data4 = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1;
         checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL dflt_ready%0d got=%b want=1", i, in_ready4); end
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
      while (pkts4 == p0 && n < 3000) begin @(posedge clk); #1; n++; end
      checks++; if (pkts4 - p0 !== 1) begin errors++; $display("FAIL dflt_pkt got=%0d want=1", pkts4 - p0); end
      checks++; if (got4.size() !== 11) begin errors++; $display("FAIL dflt_len got=%0d want=11", got4.size()); end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (got4[i] !== exp[i]) begin errors++; $display("FAIL dflt_byte%0d got=%h want=%h", i, got4[i], exp[i]); end
      end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL dflt_busy got=%b want=0", busy4); end
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_valid4 = 1'b0;
      in_data4  = 16'h0000;
      test_reset();
      test_basic();
      test_long_done();
      test_hold_valid();
      test_reset_mid();
      test_bursts();
      test_default_words();
      checks++; if (violations !== 0) begin errors++; $display("FAIL final_start_while_busy got=%0d want=0", violations); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
